// File: rtl/regfile_wb_arbiter.sv
// Arbitrates N_REQ writeback sources onto the single 64-bit register-file write port,
// lane-aligning sub-dword data. Define WB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [5*N_REQ-1:0]    req_addr,
  input  logic [64*N_REQ-1:0]   req_data,
  input  logic [2*N_REQ-1:0]    req_size,
  input  logic [3*N_REQ-1:0]    req_off,
  output logic                  rf_wena,
  output logic [4:0]            rf_waddr,
  output logic [63:0]           rf_wdata,
  output logic [7:0]            rf_sel,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic          gnt_any;
  logic [IW-1:0] gnt_idx;

`ifdef WB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
  int            rr_idx;

  // Walk candidates from farthest to nearest so the one right after ptr wins last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = int'({1'b0, ptr}) + k;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      if (req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr <= IW'(N_REQ - 1);
    else if (gnt_any) ptr <= gnt_idx;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  // Handshake: a transfer happens on a clock edge where req_valid[i] & req_ready[i];
  // ready is combinational, one-hot or zero, never given to an idle requester or during rst,
  // and requesters keep addr/data/size/off stable until they see ready.
  always_comb begin
    req_ready = '0;
    if (gnt_any && !rst) req_ready[gnt_idx] = 1'b1;
  end

  logic [4:0]  s_addr;
  logic [63:0] s_data;
  logic [1:0]  s_size;
  logic [2:0]  s_off;

  assign s_addr = req_addr[5*gnt_idx +: 5];
  assign s_data = req_data[64*gnt_idx +: 64];
  assign s_size = req_size[2*gnt_idx +: 2];
  assign s_off  = req_off[3*gnt_idx +: 3];

  logic [2:0]  aoff;
  logic [7:0]  base_sel;
  logic [63:0] masked;
  logic [7:0]  al_sel;
  logic [63:0] al_data;

  // Offset is rounded down to the natural alignment of the access size.
  always_comb begin
    aoff     = 3'd0;
    base_sel = 8'hFF;
    masked   = s_data;
    case (s_size)
      2'd0: begin
        aoff     = s_off;
        base_sel = 8'h01;
        masked   = {56'd0, s_data[7:0]};
      end
      2'd1: begin
        aoff     = {s_off[2:1], 1'b0};
        base_sel = 8'h03;
        masked   = {48'd0, s_data[15:0]};
      end
      2'd2: begin
        aoff     = {s_off[2], 2'b00};
        base_sel = 8'h0F;
        masked   = {32'd0, s_data[31:0]};
      end
      default: begin
        aoff     = 3'd0;
        base_sel = 8'hFF;
        masked   = s_data;
      end
    endcase
    al_sel  = base_sel << aoff;
    al_data = masked << {aoff, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wena  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_sel   <= '0;
    end else begin
      // Writes to x0 complete the handshake but never enable the register file.
      rf_wena <= gnt_any && (s_addr != 5'd0);
      if (gnt_any) begin
        rf_waddr <= s_addr;
        rf_wdata <= al_data;
        rf_sel   <= al_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      conflict_cnt <= '0;
    else if (($countones(req_valid) >= 2) && (conflict_cnt != {CNT_W{1'b1}}))
      conflict_cnt <= conflict_cnt + 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a cycle model predicts grants, lane-aligned
// rf_* results (queued one cycle ahead) and the conflict counter; honours WB_ROUND_ROBIN_EN.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int CW = 4;
  localparam int EW = 1 + 5 + 64 + 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_addr;
  logic [64*N-1:0] req_data;
  logic [2*N-1:0]  req_size;
  logic [3*N-1:0]  req_off;
  logic            rf_wena;
  logic [4:0]      rf_waddr;
  logic [63:0]     rf_wdata;
  logic [7:0]      rf_sel;
  logic [CW-1:0]   conflict_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .req_off(req_off),
    .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_sel(rf_sel),
    .conflict_cnt(conflict_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  int          m_ptr = N - 1;
  logic [CW-1:0] m_cnt = '0;
  logic [4:0]  m_waddr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_sel = '0;
  int          last_grant = -1;
  logic [N-1:0] last_ready = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-by-byte placement: returns {sel, data}.
  function automatic logic [71:0] lane(input logic [63:0] d, input logic [1:0] sz, input logic [2:0] off);
    logic [7:0]  sel;
    logic [63:0] data;
    int nb;
    int base;
    sel  = '0;
    data = '0;
    nb   = 1 << sz;
    base = (int'(off) / nb) * nb;
    for (int b = 0; b < 8; b++) begin
      if (b >= base && b < base + nb) begin
        sel[b] = 1'b1;
        data[8*b +: 8] = d[8*(b-base) +: 8];
      end
    end
    return {sel, data};
  endfunction

  function automatic int model_grant();
    int g;
    g = -1;
    if (rst) return -1;
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && req_valid[i]) g = i;
    end
`else
    for (int i = 0; i < N; i++)
      if (g < 0 && req_valid[i]) g = i;
`endif
    return g;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d,
                         input logic [1:0] s, input logic [2:0] o);
    req_valid[i]      = v;
    req_addr[5*i +: 5]   = a;
    req_data[64*i +: 64] = d;
    req_size[2*i +: 2]   = s;
    req_off[3*i +: 3]    = o;
  endtask

  // One clock: compare at negedge, predict the next registered result, return #1 after posedge.
  task automatic cycle();
    logic [EW-1:0] e;
    logic [71:0]   ln;
    logic [N-1:0]  er;
    int g;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_out", {rf_wena, rf_waddr, rf_wdata, rf_sel}, e);
    end
    check("conflict_cnt", conflict_cnt, m_cnt);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", req_ready, er);
    last_grant = g;
    last_ready = req_ready;
    if (rst) begin
      m_waddr = '0; m_wdata = '0; m_sel = '0; m_cnt = '0; m_ptr = N - 1;
      exp_q.push_back('0);
    end else begin
      if (g >= 0) begin
        ln = lane(req_data[64*g +: 64], req_size[2*g +: 2], req_off[3*g +: 3]);
        m_waddr = req_addr[5*g +: 5];
        m_sel   = ln[71:64];
        m_wdata = ln[63:0];
        m_ptr   = g;
      end
      exp_q.push_back({(g >= 0) && (m_waddr != 5'd0), m_waddr, m_wdata, m_sel});
      if ($countones(req_valid) >= 2 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_g;
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0; req_size = '0; req_off = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 64'hA5A5_0000_0000_0000 + 64'(i), 2'd3, 3'd0);
    @(posedge clk);
    #1;

    // Reset with every requester valid
    cycle();
    check("t1_ready", last_ready, '0);
    cycle();
    check("t1_wena", rf_wena, 0);
    check("t1_sel", rf_sel, 0);
    check("t1_cnt", conflict_cnt, 0);
    rst = 1'b0;
    req_valid = '0;
    cycle();

    // Single dword write
    set_req(0, 1'b1, 5'd5, 64'h1122334455667788, 2'd3, 3'd0);
    cycle();
    check("t2_ready", last_ready, 3'b001);
    check("t2_wena", rf_wena, 1);
    check("t2_waddr", rf_waddr, 5);
    check("t2_wdata", rf_wdata, 64'h1122334455667788);
    check("t2_sel", rf_sel, 8'hFF);
    req_valid = '0;
    cycle();
    check("t2_idle_wena", rf_wena, 0);

    // Lane alignment
    set_req(1, 1'b1, 5'd9, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 3'd6);
    cycle();
    check("t3_b_wdata", rf_wdata, 64'h00AB000000000000);
    check("t3_b_sel", rf_sel, 8'h40);
    set_req(1, 1'b1, 5'd9, 64'h1234_5678_9ABC_BEEF, 2'd1, 3'd3);
    cycle();
    check("t3_h_wdata", rf_wdata, 64'h00000000BEEF0000);
    check("t3_h_sel", rf_sel, 8'h0C);
    req_valid = '0;
    cycle();

    // Contention from a fresh reset so the pointer starts at N-1
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 64'hC0DE_0000_0000_0000 + 64'(i), 2'd3, 3'd0);
    for (int c = 0; c < 6; c++) begin
      cycle();
`ifdef WB_ROUND_ROBIN_EN
      exp_g = c % 3;
`else
      exp_g = 0;
`endif
      check("t4_grant", last_ready, 3'(1 << exp_g));
    end
    check("t4_cnt", conflict_cnt, 6);
    req_valid = '0;
    cycle();

    // Register 0 write is accepted but not enabled
    set_req(2, 1'b1, 5'd0, 64'hDEAD_BEEF_0000_0001, 2'd3, 3'd0);
    cycle();
    check("t5_ready", last_ready, 3'b100);
    check("t5_wena", rf_wena, 0);
    check("t5_waddr", rf_waddr, 0);
    set_req(2, 1'b1, 5'd7, 64'hDEAD_BEEF_0000_0002, 2'd3, 3'd0);
    cycle();
    check("t5b_wena", rf_wena, 1);
    check("t5b_waddr", rf_waddr, 7);
    req_valid = '0;
    cycle();

    // Random traffic; a requester only changes its request after being granted
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++)
        if (last_grant == i || !req_valid[i])
          set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      cycle();
    end

    // Saturation, then reset mid-stream
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 10), 64'h5A5A_0000_0000_0000 + 64'(i), 2'd3, 3'd0);
    for (int c = 0; c < 20; c++) cycle();
    check("t6_cnt_sat", conflict_cnt, 15);
    check("t6_wena_before", rf_wena, 1);
    rst = 1'b1;
    cycle();
    check("t6_ready_rst", last_ready, '0);
    check("t6_wena_after", rf_wena, 0);
    check("t6_cnt_after", conflict_cnt, 0);
    rst = 1'b0;
    req_valid = '0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
